march_bist: RTL and testbench

Parametrised March C- built-in self-test engine for the single-port-per-direction RAM (separate read/write address ports, registered read data). It replaces the fixed counter/pattern BIST with configurable address and data width, configurable read latency, and first-failure diagnostics. It sits between the functional RAM clients and the RAM, multiplexing the RAM ports onto the engine while a test runs. It reports pass/fail, the failing address/element/data, and a failure count.

---
 rtl/march_bist_pkg.sv | 49 ++++
 rtl/march_bist_if.sv | 27 ++
 rtl/march_bist_cmp_pipe.sv | 58 +++++
 rtl/march_bist.sv | 195 +++++++++++++++++++
 tb/tb_march_bist.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/march_bist_pkg.sv
// Shared types for the March C- BIST engine: FSM states, element indices
// and the per-element operation table.
package march_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int ELEM_W = 3;

    localparam logic [ELEM_W-1:0] M0 = 3'd0;
    localparam logic [ELEM_W-1:0] M1 = 3'd1;
    localparam logic [ELEM_W-1:0] M2 = 3'd2;
    localparam logic [ELEM_W-1:0] M3 = 3'd3;
    localparam logic [ELEM_W-1:0] M4 = 3'd4;
    localparam logic [ELEM_W-1:0] M5 = 3'd5;

    // rd_one / wr_one select the all-ones pattern, otherwise all-zeros
    typedef struct packed {
        logic down;
        logic rd;
        logic rd_one;
        logic wr;
        logic wr_one;
    } op_t;

    function automatic logic elem_down(input logic [ELEM_W-1:0] elem);
        return (elem == M3) || (elem == M4);
    endfunction

    function automatic op_t elem_op(input logic [ELEM_W-1:0] elem);
        op_t op;
        op = '0;
        case (elem)
            M0:      op = '{down: 1'b0, rd: 1'b0, rd_one: 1'b0, wr: 1'b1, wr_one: 1'b0};
            M1:      op = '{down: 1'b0, rd: 1'b1, rd_one: 1'b0, wr: 1'b1, wr_one: 1'b1};
            M2:      op = '{down: 1'b0, rd: 1'b1, rd_one: 1'b1, wr: 1'b1, wr_one: 1'b0};
            M3:      op = '{down: 1'b1, rd: 1'b1, rd_one: 1'b0, wr: 1'b1, wr_one: 1'b1};
            M4:      op = '{down: 1'b1, rd: 1'b1, rd_one: 1'b1, wr: 1'b1, wr_one: 1'b0};
            M5:      op = '{down: 1'b0, rd: 1'b1, rd_one: 1'b0, wr: 1'b0, wr_one: 1'b0};
            default: op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/march_bist_if.sv
// RAM-side port bundle: separate read/write address ports, registered read data.
interface march_bist_if #(
    parameter int AW = 10,
    parameter int DW = 8
) ();
    logic [AW-1:0] ram_rd_addr;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic          ram_wr_en;
    logic [DW-1:0] ram_rd_data;

    modport master (
        output ram_rd_addr,
        output ram_wr_addr,
        output ram_wr_data,
        output ram_wr_en,
        input  ram_rd_data
    );

    modport slave (
        input  ram_rd_addr,
        input  ram_wr_addr,
        input  ram_wr_data,
        input  ram_wr_en,
        output ram_rd_data
    );
endinterface

// File: rtl/march_bist_cmp_pipe.sv
// Read-tag delay line matching the RAM read latency, plus the data comparator
// that flags a miscompare when a tagged read returns.
module bist_cmp_pipe
    import march_bist_pkg::*;
#(
    parameter int AW     = 10,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [DW-1:0]     i_exp,
    input  logic [AW-1:0]     i_addr,
    input  logic [ELEM_W-1:0] i_elem,
    input  logic [DW-1:0]     i_rd_data,
    output logic              o_miscmp,
    output logic [AW-1:0]     o_addr,
    output logic [ELEM_W-1:0] o_elem,
    output logic [DW-1:0]     o_exp,
    output logic [DW-1:0]     o_act
);

    typedef struct packed {
        logic              valid;
        logic [DW-1:0]     exp;
        logic [AW-1:0]     addr;
        logic [ELEM_W-1:0] elem;
    } tag_t;

    // w_tap[0] is the issuing cycle, w_tap[RD_LAT] lines up with ram read data
    tag_t w_tap [RD_LAT+1];

    assign w_tap[0] = '{valid: i_valid, exp: i_exp, addr: i_addr, elem: i_elem};

    generate
        for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_stage
            tag_t r_tag;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= w_tap[gi];
                end
            end

            assign w_tap[gi+1] = r_tag;
        end
    endgenerate

    assign o_miscmp = w_tap[RD_LAT].valid && (i_rd_data != w_tap[RD_LAT].exp);
    assign o_addr   = w_tap[RD_LAT].addr;
    assign o_elem   = w_tap[RD_LAT].elem;
    assign o_exp    = w_tap[RD_LAT].exp;
    assign o_act    = i_rd_data;

endmodule

// File: rtl/march_bist.sv
// March C- BIST engine: takes over the RAM ports while running, sequences the
// six March elements and records pass/fail with first-failure diagnostics.
module march_bist
    import march_bist_pkg::*;
#(
    parameter int AW           = 10,
    parameter int DW           = 8,
    parameter int RD_LAT       = 1,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     sys_rd_addr,
    input  logic [AW-1:0]     sys_wr_addr,
    input  logic [DW-1:0]     sys_wr_data,
    input  logic              sys_wr_en,
    march_bist_if.master      ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [AW-1:0]     fail_addr,
    output logic [ELEM_W-1:0] fail_elem,
    output logic [DW-1:0]     fail_exp,
    output logic [DW-1:0]     fail_act,
    output logic [15:0]       fail_count
);

    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_addr;
    logic [ELEM_W-1:0] r_elem;
    logic              r_phase;
    logic [CW-1:0]     r_drain_cnt;

    logic [AW-1:0]     r_fail_addr;
    logic [ELEM_W-1:0] r_fail_elem;
    logic [DW-1:0]     r_fail_exp;
    logic [DW-1:0]     r_fail_act;
    logic [15:0]       r_fail_count;

    op_t               w_op;
    logic              w_run;
    logic              w_busy;
    logic              w_start_acc;
    logic              w_is_rd;
    logic              w_is_wr;
    logic              w_addr_done;
    logic              w_term;
    logic              w_last_op;
    logic              w_stop;
    logic [ELEM_W-1:0] w_elem_next;
    logic              w_fail_hit;

    logic              w_miscmp;
    logic [AW-1:0]     w_cmp_addr;
    logic [ELEM_W-1:0] w_cmp_elem;
    logic [DW-1:0]     w_cmp_exp;
    logic [DW-1:0]     w_cmp_act;

    assign w_run       = (r_state == ST_RUN);
    assign w_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Read-then-write elements spend phase 0 reading and phase 1 writing
    assign w_op        = elem_op(r_elem);
    assign w_is_rd     = w_run && w_op.rd && (!w_op.wr || !r_phase);
    assign w_is_wr     = w_run && w_op.wr && (!w_op.rd || r_phase);
    assign w_addr_done = !(w_op.rd && w_op.wr) || r_phase;
    assign w_term      = w_op.down ? (r_addr == '0) : (r_addr == '1);
    assign w_last_op   = w_run && (r_elem == M5) && w_addr_done && w_term;
    assign w_elem_next = r_elem + 3'd1;
    assign w_fail_hit  = w_busy && w_miscmp;
    assign w_stop      = (STOP_ON_FAIL != 0) && w_fail_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last_op || w_stop) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Address/element sequencer; the counter never wraps visibly because the
    // element changes on the terminal address and reloads the start address.
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_addr  <= '0;
            r_elem  <= M0;
            r_phase <= 1'b0;
        end else if (w_run) begin
            if (w_addr_done) begin
                r_phase <= 1'b0;
                if (w_term) begin
                    r_elem <= w_elem_next;
                    r_addr <= elem_down(w_elem_next) ? '1 : '0;
                end else begin
                    r_addr <= w_op.down ? (r_addr - AW'(1)) : (r_addr + AW'(1));
                end
            end else begin
                r_phase <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_DRAIN)) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + CW'(1);
        end
    end

    bist_cmp_pipe #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (w_is_rd),
        .i_exp     ({DW{w_op.rd_one}}),
        .i_addr    (r_addr),
        .i_elem    (r_elem),
        .i_rd_data (ram.ram_rd_data),
        .o_miscmp  (w_miscmp),
        .o_addr    (w_cmp_addr),
        .o_elem    (w_cmp_elem),
        .o_exp     (w_cmp_exp),
        .o_act     (w_cmp_act)
    );

    // Diagnostics capture only the first miscompare; the count keeps going
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_fail_addr  <= '0;
            r_fail_elem  <= '0;
            r_fail_exp   <= '0;
            r_fail_act   <= '0;
            r_fail_count <= '0;
        end else if (w_fail_hit) begin
            if (r_fail_count != 16'hFFFF) begin
                r_fail_count <= r_fail_count + 16'd1;
            end
            if (r_fail_count == 16'd0) begin
                r_fail_addr <= w_cmp_addr;
                r_fail_elem <= w_cmp_elem;
                r_fail_exp  <= w_cmp_exp;
                r_fail_act  <= w_cmp_act;
            end
        end
    end

    assign ram.ram_rd_addr = w_busy ? r_addr : sys_rd_addr;
    assign ram.ram_wr_addr = w_busy ? r_addr : sys_wr_addr;
    assign ram.ram_wr_data = w_busy ? {DW{w_op.wr_one}} : sys_wr_data;
    assign ram.ram_wr_en   = w_busy ? w_is_wr : sys_wr_en;

    assign busy       = w_busy;
    assign done       = (r_state == ST_DONE);
    assign pass       = done && (r_fail_count == 16'd0);
    assign fail       = done && (r_fail_count != 16'd0);
    assign fail_addr  = r_fail_addr;
    assign fail_elem  = r_fail_elem;
    assign fail_exp   = r_fail_exp;
    assign fail_act   = r_fail_act;
    assign fail_count = r_fail_count;

endmodule

// File: tb/tb_march_bist.sv
// Directed bench: three engines (AW=4/RD_LAT=1, AW=4/RD_LAT=2 stop-on-fail,
// AW=10) each on a behavioural RAM with an optional stuck-at-1 on addr 5 bit 0.
module tb_march_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic       fault_a = 1'b0, fault_b = 1'b0;
    logic [3:0] s_rd_addr = '0, s_wr_addr = '0;
    logic [7:0] s_wr_data = '0;
    logic       s_wr_en = 1'b0;
    logic [9:0] c_rd_addr = '0, c_wr_addr = '0;
    logic [7:0] c_wr_data = '0;
    logic       c_wr_en = 1'b0;

    logic busy_a, done_a, pass_a, fail_a, busy_b, done_b, pass_b, fail_b, busy_c, done_c, pass_c, fail_c;
    logic [3:0]  fail_addr_a, fail_addr_b;
    logic [9:0]  fail_addr_c;
    logic [2:0]  fail_elem_a, fail_elem_b, fail_elem_c;
    logic [7:0]  fail_exp_a, fail_act_a, fail_exp_b, fail_act_b, fail_exp_c, fail_act_c;
    logic [15:0] fail_count_a, fail_count_b, fail_count_c;

    march_bist_if #(.AW(4),  .DW(8)) ram_a ();
    march_bist_if #(.AW(4),  .DW(8)) ram_b ();
    march_bist_if #(.AW(10), .DW(8)) ram_c ();

    march_bist #(.AW(4), .DW(8), .RD_LAT(1), .STOP_ON_FAIL(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .sys_rd_addr(s_rd_addr), .sys_wr_addr(s_wr_addr), .sys_wr_data(s_wr_data), .sys_wr_en(s_wr_en),
        .ram(ram_a), .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
        .fail_addr(fail_addr_a), .fail_elem(fail_elem_a), .fail_exp(fail_exp_a), .fail_act(fail_act_a),
        .fail_count(fail_count_a)
    );

    march_bist #(.AW(4), .DW(8), .RD_LAT(2), .STOP_ON_FAIL(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .sys_rd_addr(s_rd_addr), .sys_wr_addr(s_wr_addr), .sys_wr_data(s_wr_data), .sys_wr_en(s_wr_en),
        .ram(ram_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .fail_addr(fail_addr_b), .fail_elem(fail_elem_b), .fail_exp(fail_exp_b), .fail_act(fail_act_b),
        .fail_count(fail_count_b)
    );

    march_bist #(.AW(10), .DW(8), .RD_LAT(1), .STOP_ON_FAIL(0)) dut_c (
        .clk(clk), .rst(rst), .start(start_c),
        .sys_rd_addr(c_rd_addr), .sys_wr_addr(c_wr_addr), .sys_wr_data(c_wr_data), .sys_wr_en(c_wr_en),
        .ram(ram_c), .busy(busy_c), .done(done_c), .pass(pass_c), .fail(fail_c),
        .fail_addr(fail_addr_c), .fail_elem(fail_elem_c), .fail_exp(fail_exp_c), .fail_act(fail_act_c),
        .fail_count(fail_count_c)
    );

    // Behavioural RAMs; the fault is modelled on the read path
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [7:0] mem_c [1024];
    logic [7:0] rdq_a, rdq1_b, rdq2_b, rdq_c;

    always @(posedge clk) begin
        if (ram_a.ram_wr_en) mem_a[ram_a.ram_wr_addr] <= ram_a.ram_wr_data;
        rdq_a <= mem_a[ram_a.ram_rd_addr] | ((fault_a && ram_a.ram_rd_addr == 4'd5) ? 8'h01 : 8'h00);
        if (ram_b.ram_wr_en) mem_b[ram_b.ram_wr_addr] <= ram_b.ram_wr_data;
        rdq1_b <= mem_b[ram_b.ram_rd_addr] | ((fault_b && ram_b.ram_rd_addr == 4'd5) ? 8'h01 : 8'h00);
        rdq2_b <= rdq1_b;
        if (ram_c.ram_wr_en) mem_c[ram_c.ram_wr_addr] <= ram_c.ram_wr_data;
        rdq_c <= mem_c[ram_c.ram_rd_addr];
    end

    assign ram_a.ram_rd_data = rdq_a;
    assign ram_b.ram_rd_data = rdq2_b;
    assign ram_c.ram_rd_data = rdq_c;

    // Leaves the caller at #1 into cycle k+1, where edge k sampled start
    task automatic pulse_start(input int which);
        @(posedge clk); #1;
        case (which)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    task automatic wait_done(input int which, input int cyc0, input int limit, output int cyc);
        logic d;
        cyc = cyc0;
        d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        while (!d && cyc < limit) begin
            @(posedge clk); #1;
            cyc++;
            d = (which == 0) ? done_a : (which == 1) ? done_b : done_c;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_rd_addr = 4'hA; s_wr_addr = 4'h3; s_wr_data = 8'h5C; s_wr_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        n_vec++; if ({done_a, pass_a, fail_a} !== 3'b000) begin n_err++; $display("FAIL reset_done_pass_fail got=%b want=000", {done_a, pass_a, fail_a}); end
        n_vec++; if (fail_count_a !== 16'd0) begin n_err++; $display("FAIL reset_fail_count got=%0d want=0", fail_count_a); end
        n_vec++; if ({fail_addr_a, fail_elem_a, fail_exp_a, fail_act_a} !== 23'd0) begin n_err++; $display("FAIL reset_diag got=%h want=0", {fail_addr_a, fail_elem_a, fail_exp_a, fail_act_a}); end
        n_vec++; if ({busy_b, done_b, busy_c, done_c} !== 4'b0000) begin n_err++; $display("FAIL reset_other_busy_done got=%b want=0000", {busy_b, done_b, busy_c, done_c}); end
        n_vec++; if (ram_a.ram_rd_addr !== 4'hA) begin n_err++; $display("FAIL idle_rd_addr_pass got=%h want=a", ram_a.ram_rd_addr); end
        n_vec++; if ({ram_a.ram_wr_addr, ram_a.ram_wr_data, ram_a.ram_wr_en} !== {4'h3, 8'h5C, 1'b1}) begin n_err++; $display("FAIL idle_wr_pass got=%h want=%h", {ram_a.ram_wr_addr, ram_a.ram_wr_data, ram_a.ram_wr_en}, {4'h3, 8'h5C, 1'b1}); end
        s_wr_en = 1'b0;
        $display("test_reset: reset values and idle pass-through checked");
    endtask

    task automatic test_fault_free();
        int cyc;
        fault_a = 1'b0;
        pulse_start(0);
        n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL ff_busy_k1 got=%b want=1", busy_a); end
        n_vec++; if ({ram_a.ram_wr_en, ram_a.ram_wr_addr, ram_a.ram_wr_data} !== {1'b1, 4'd0, 8'h00}) begin n_err++; $display("FAIL ff_first_op got=%h want=%h", {ram_a.ram_wr_en, ram_a.ram_wr_addr, ram_a.ram_wr_data}, {1'b1, 4'd0, 8'h00}); end
        @(posedge clk); #1;
        n_vec++; if (ram_a.ram_wr_addr !== 4'd1) begin n_err++; $display("FAIL ff_m0_addr1 got=%0d want=1", ram_a.ram_wr_addr); end
        repeat (15) @(posedge clk);
        #1;
        // cycle 17: first M1 read of addr 0
        n_vec++; if ({ram_a.ram_wr_en, ram_a.ram_rd_addr} !== {1'b0, 4'd0}) begin n_err++; $display("FAIL ff_m1_read got=%h want=%h", {ram_a.ram_wr_en, ram_a.ram_rd_addr}, {1'b0, 4'd0}); end
        @(posedge clk); #1;
        n_vec++; if ({ram_a.ram_wr_en, ram_a.ram_wr_addr, ram_a.ram_wr_data} !== {1'b1, 4'd0, 8'hFF}) begin n_err++; $display("FAIL ff_m1_write got=%h want=%h", {ram_a.ram_wr_en, ram_a.ram_wr_addr, ram_a.ram_wr_data}, {1'b1, 4'd0, 8'hFF}); end
        repeat (63) @(posedge clk);
        #1;
        // cycle 81: M3 starts descending at N-1
        n_vec++; if ({ram_a.ram_wr_en, ram_a.ram_rd_addr} !== {1'b0, 4'd15}) begin n_err++; $display("FAIL ff_m3_start got=%h want=%h", {ram_a.ram_wr_en, ram_a.ram_rd_addr}, {1'b0, 4'd15}); end
        wait_done(0, 81, 400, cyc);
        n_vec++; if (cyc !== 162) begin n_err++; $display("FAIL ff_done_cycle got=%0d want=162", cyc); end
        n_vec++; if ({busy_a, pass_a, fail_a} !== 3'b010) begin n_err++; $display("FAIL ff_result got=%b want=010", {busy_a, pass_a, fail_a}); end
        n_vec++; if (fail_count_a !== 16'd0) begin n_err++; $display("FAIL ff_count got=%0d want=0", fail_count_a); end
        $display("test_fault_free: done at cycle %0d pass=%b", cyc, pass_a);
    endtask

    task automatic test_stuck_at();
        int cyc;
        fault_a = 1'b1;
        pulse_start(0);
        wait_done(0, 1, 400, cyc);
        n_vec++; if (cyc !== 162) begin n_err++; $display("FAIL sa_done_cycle got=%0d want=162", cyc); end
        n_vec++; if ({pass_a, fail_a} !== 2'b01) begin n_err++; $display("FAIL sa_pass_fail got=%b want=01", {pass_a, fail_a}); end
        n_vec++; if (fail_addr_a !== 4'd5) begin n_err++; $display("FAIL sa_addr got=%0d want=5", fail_addr_a); end
        n_vec++; if (fail_elem_a !== 3'd1) begin n_err++; $display("FAIL sa_elem got=%0d want=1", fail_elem_a); end
        n_vec++; if ({fail_exp_a, fail_act_a} !== {8'h00, 8'h01}) begin n_err++; $display("FAIL sa_exp_act got=%h want=0001", {fail_exp_a, fail_act_a}); end
        n_vec++; if (fail_count_a !== 16'd3) begin n_err++; $display("FAIL sa_count got=%0d want=3", fail_count_a); end
        $display("test_stuck_at: addr=%0d elem=%0d count=%0d", fail_addr_a, fail_elem_a, fail_count_a);
    endtask

    task automatic test_restart_clears();
        int cyc;
        fault_a = 1'b0;
        pulse_start(0);
        n_vec++; if ({busy_a, done_a, fail_a} !== 3'b100) begin n_err++; $display("FAIL rs_state got=%b want=100", {busy_a, done_a, fail_a}); end
        n_vec++; if ({fail_count_a, fail_addr_a, fail_elem_a, fail_act_a} !== 31'd0) begin n_err++; $display("FAIL rs_cleared got=%h want=0", {fail_count_a, fail_addr_a, fail_elem_a, fail_act_a}); end
        repeat (49) @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done(0, 51, 400, cyc);
        n_vec++; if (cyc !== 162) begin n_err++; $display("FAIL rs_done_cycle got=%0d want=162", cyc); end
        n_vec++; if ({pass_a, fail_count_a} !== {1'b1, 16'd0}) begin n_err++; $display("FAIL rs_result got=%h want=10000", {pass_a, fail_count_a}); end
        $display("test_restart_clears: rerun done at cycle %0d pass=%b", cyc, pass_a);
    endtask

    task automatic test_stop_on_fail();
        int cyc;
        fault_b = 1'b1;
        pulse_start(1);
        // M1 read of addr 5 in cycle 27, seen in cycle 29, done in cycle 32
        repeat (30) @(posedge clk);
        #1;
        n_vec++; if ({busy_b, done_b} !== 2'b10) begin n_err++; $display("FAIL sof_cyc31 got=%b want=10", {busy_b, done_b}); end
        wait_done(1, 31, 400, cyc);
        n_vec++; if (cyc !== 32) begin n_err++; $display("FAIL sof_done_cycle got=%0d want=32", cyc); end
        n_vec++; if ({busy_b, fail_b, pass_b} !== 3'b010) begin n_err++; $display("FAIL sof_result got=%b want=010", {busy_b, fail_b, pass_b}); end
        n_vec++; if (fail_count_b !== 16'd1) begin n_err++; $display("FAIL sof_count got=%0d want=1", fail_count_b); end
        n_vec++; if ({fail_addr_b, fail_elem_b, fail_exp_b, fail_act_b} !== {4'd5, 3'd1, 8'h00, 8'h01}) begin n_err++; $display("FAIL sof_diag got=%h want=%h", {fail_addr_b, fail_elem_b, fail_exp_b, fail_act_b}, {4'd5, 3'd1, 8'h00, 8'h01}); end
        $display("test_stop_on_fail: done at cycle %0d count=%0d", cyc, fail_count_b);
    endtask

    task automatic test_rst_mid_run();
        int cyc;
        fault_a = 1'b1;
        pulse_start(0);
        repeat (89) @(posedge clk);
        #1;
        // cycle 90 is inside M3; the M1 failure has already been recorded
        n_vec++; if ({busy_a, fail_count_a} !== {1'b1, 16'd1}) begin n_err++; $display("FAIL rm_before got=%h want=10001", {busy_a, fail_count_a}); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++; if ({busy_a, done_a, pass_a, fail_a} !== 4'b0000) begin n_err++; $display("FAIL rm_state got=%b want=0000", {busy_a, done_a, pass_a, fail_a}); end
        n_vec++; if ({fail_count_a, fail_addr_a, fail_elem_a, fail_exp_a, fail_act_a} !== 39'd0) begin n_err++; $display("FAIL rm_diag got=%h want=0", {fail_count_a, fail_addr_a, fail_elem_a, fail_exp_a, fail_act_a}); end
        rst = 1'b0;
        fault_a = 1'b0;
        pulse_start(0);
        wait_done(0, 1, 400, cyc);
        n_vec++; if ({cyc == 162, pass_a} !== 2'b11) begin n_err++; $display("FAIL rm_rerun got=cycle %0d pass %b want=cycle 162 pass 1", cyc, pass_a); end
        $display("test_rst_mid_run: rerun done at cycle %0d pass=%b", cyc, pass_a);
    endtask

    task automatic test_passthrough();
        c_wr_addr = 10'd100; c_wr_data = 8'hFF; c_wr_en = 1'b1;
        #1;
        n_vec++; if ({ram_c.ram_wr_en, ram_c.ram_wr_addr, ram_c.ram_wr_data} !== {1'b1, 10'd100, 8'hFF}) begin n_err++; $display("FAIL pt_write got=%h want=%h", {ram_c.ram_wr_en, ram_c.ram_wr_addr, ram_c.ram_wr_data}, {1'b1, 10'd100, 8'hFF}); end
        @(posedge clk); #1;
        c_wr_en = 1'b0;
        c_rd_addr = 10'd100;
        @(posedge clk); #1;
        n_vec++; if (ram_c.ram_rd_data !== 8'hFF) begin n_err++; $display("FAIL pt_readback got=%h want=ff", ram_c.ram_rd_data); end
        $display("test_passthrough: addr 100 read back %h", ram_c.ram_rd_data);
    endtask

    task automatic test_busy_masks_sys();
        int cyc;
        logic d;
        c_wr_addr = 10'd100; c_wr_data = 8'hA5; c_wr_en = 1'b1;
        pulse_start(2);
        n_vec++; if ({busy_c, ram_c.ram_wr_addr, ram_c.ram_wr_data} !== {1'b1, 10'd0, 8'h00}) begin n_err++; $display("FAIL mask_first_op got=%h want=%h", {busy_c, ram_c.ram_wr_addr, ram_c.ram_wr_data}, {1'b1, 10'd0, 8'h00}); end
        cyc = 1;
        d = done_c;
        while (!d && cyc < 12000) begin
            @(posedge clk); #1;
            cyc++;
            d = done_c;
            if (cyc == 9 * 1024 + 5) begin
                n_vec++; if (ram_c.ram_wr_en !== 1'b0) begin n_err++; $display("FAIL mask_m5_wr_en got=%b want=0", ram_c.ram_wr_en); end
            end
        end
        c_wr_en = 1'b0;
        n_vec++; if (cyc !== 10242) begin n_err++; $display("FAIL mask_done_cycle got=%0d want=10242", cyc); end
        n_vec++; if ({pass_c, fail_count_c} !== {1'b1, 16'd0}) begin n_err++; $display("FAIL mask_result got=%h want=10000", {pass_c, fail_count_c}); end
        c_rd_addr = 10'd100;
        @(posedge clk); #1;
        n_vec++; if (ram_c.ram_rd_data !== 8'h00) begin n_err++; $display("FAIL mask_addr100 got=%h want=00", ram_c.ram_rd_data); end
        $display("test_busy_masks_sys: done at cycle %0d addr 100 holds %h", cyc, ram_c.ram_rd_data);
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_restart_clears();
        test_stop_on_fail();
        test_rst_mid_run();
        test_passthrough();
        test_busy_masks_sys();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
